// File: rtl/divider.sv
// Radix-2 restoring divider: 32-bit signed/unsigned, one quotient bit per cycle.
// result_o = {remainder, quotient}; ready_o pulses for one cycle in DONE.
module divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDivZero, StDone} state_e;

  state_e      r_state;
  logic [5:0]  r_cnt;
  logic [31:0] r_dvd;     // dividend magnitude, shifted out MSB-first
  logic [31:0] r_dvs;     // divisor magnitude
  logic [31:0] r_rem;     // partial remainder, always below r_dvs
  logic [31:0] r_quot;
  logic        r_q_neg;
  logic        r_r_neg;

  logic        w_sign1;
  logic        w_sign2;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_diff;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_next;
  logic [5:0]  w_cnt_next;
  logic [31:0] w_q_fix;
  logic [31:0] w_r_fix;

  // Operand magnitudes and signs at accept, plus one restoring step of the datapath
  always_comb begin
    w_sign1     = signed_div & opdata1[31];
    w_sign2     = signed_div & opdata2[31];
    w_mag1      = w_sign1 ? (~opdata1 + 32'd1) : opdata1;
    w_mag2      = w_sign2 ? (~opdata2 + 32'd1) : opdata2;
    w_shift     = {r_rem, r_dvd[31]};
    w_ge        = (w_shift >= {1'b0, r_dvs});
    // True difference is below r_dvs, so modulo-2^32 subtraction is exact
    w_diff      = w_shift[31:0] - r_dvs;
    w_rem_next  = w_ge ? w_diff : w_shift[31:0];
    w_quot_next = {r_quot[30:0], w_ge};
    w_cnt_next  = r_cnt + 6'd1;
    w_q_fix     = r_q_neg ? (~w_quot_next + 32'd1) : w_quot_next;
    w_r_fix     = r_r_neg ? (~w_rem_next + 32'd1) : w_rem_next;
  end

  // Control FSM with registered result/ready; annul overrides every state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= 6'd0;
      r_dvd    <= 32'd0;
      r_dvs    <= 32'd0;
      r_rem    <= 32'd0;
      r_quot   <= 32'd0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      result_o <= 64'h0;
      ready_o  <= 1'b0;
    end else if (annul_i) begin
      r_state  <= StIdle;
      r_cnt    <= 6'd0;
      result_o <= 64'h0;
      ready_o  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          ready_o <= 1'b0;
          if (start_i) begin
            r_dvd   <= w_mag1;
            r_dvs   <= w_mag2;
            r_q_neg <= w_sign1 ^ w_sign2;
            r_r_neg <= w_sign1;
            r_rem   <= 32'd0;
            r_quot  <= 32'd0;
            r_cnt   <= 6'd0;
            r_state <= (opdata2 == 32'd0) ? StDivZero : StBusy;
          end
        end
        StBusy: begin
          r_rem  <= w_rem_next;
          r_quot <= w_quot_next;
          r_dvd  <= {r_dvd[30:0], 1'b0};
          r_cnt  <= w_cnt_next;
          // The 32nd step loads the corrected result directly
          if (w_cnt_next == 6'd32) begin
            result_o <= {w_r_fix, w_q_fix};
            ready_o  <= 1'b1;
            r_state  <= StDone;
          end
        end
        StDivZero: begin
          result_o <= 64'h0;
          ready_o  <= 1'b1;
          r_state  <= StDone;
        end
        StDone: begin
          ready_o <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          ready_o <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: scoreboard of expected {result, latency}.
// Latency = clock edges from the accept edge to the first sample with ready_o high.
module tb_divider;

  logic        clk;
  logic        rst;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  typedef struct {
    logic [63:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  divider dut (
    .clk       (clk),
    .rst       (rst),
    .signed_div(signed_div),
    .opdata1   (opdata1),
    .opdata2   (opdata2),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .result_o  (result_o),
    .ready_o   (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using native SV division (truncating, remainder takes dividend sign)
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic s);
    logic signed [63:0] la, lb, q, r;
    if (b == 32'd0) return 64'h0;
    if (s) begin
      la = {{32{a[31]}}, a};
      lb = {{32{b[31]}}, b};
    end else begin
      la = {32'd0, a};
      lb = {32'd0, b};
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Push expectation and hold start for 1+extra edges; returns just after the accept edge
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [63:0] exp_res, input int extra);
    exp_t e;
    e.res = exp_res;
    e.lat = (b == 32'd0) ? 1 : 32;
    sb.push_back(e);
    opdata1    = a;
    opdata2    = b;
    signed_div = s;
    start_i    = 1'b1;
    repeat (1 + extra) @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // Wait (bounded) for ready_o; report edges waited and the result seen
  task automatic collect(output bit got, output int lat, output logic [63:0] res);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (ready_o === 1'b1) got = 1'b1;
    end
    res = result_o;
  endtask

  // Count ready_o pulses over n cycles
  task automatic count_ready(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (ready_o !== 1'b0) pulses++;
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (ready_o !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0b expected 0", ready_o);
    end
    checks++;
    if (result_o !== 64'h0) begin
      errors++; $display("FAIL reset_result: got %h expected 0", result_o);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL reset_release: ready %0b result %h expected 0/0", ready_o, result_o);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] ta[6] = '{32'd7, 32'd100, 32'hFFFF_FFFF, 32'h1234_5678, 32'd5, 32'h8000_0000};
    logic [31:0] tb[6] = '{32'd2, 32'd7, 32'd1, 32'h0000_1000, 32'd9, 32'h0000_0003};
    bit got; int lat; logic [63:0] res; exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) issue(ta[i], tb[i], 1'b0, 64'h00000001_00000003, 0);
      else        issue(ta[i], tb[i], 1'b0, model(ta[i], tb[i], 1'b0), 0);
      collect(got, lat, res);
      e = sb.pop_front();
      checks++;
      if (!got || lat != e.lat) begin
        errors++; $display("FAIL unsigned_latency[%0d]: got %0d (seen %0b) expected %0d", i, lat, got, e.lat);
      end
      checks++;
      if (res !== e.res) begin
        errors++; $display("FAIL unsigned_result[%0d]: got %h expected %h", i, res, e.res);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b0 || result_o !== e.res) begin
        errors++; $display("FAIL unsigned_pulse_hold[%0d]: ready %0b result %h expected 0 and %h", i, ready_o, result_o, e.res);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] a, b;
    bit got; int lat; logic [63:0] res; exp_t e;
    for (int i = 0; i < 7; i++) begin
      case (i)
        0: begin a = -32'sd7; b = 32'd2;   issue(a, b, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 0); end
        1: begin a = 32'd7;   b = -32'sd2; issue(a, b, 1'b1, 64'h00000001_FFFFFFFD, 0); end
        2: begin a = -32'sd100; b = -32'sd7; issue(a, b, 1'b1, model(a, b, 1'b1), 0); end
        default: begin
          a = $urandom; b = $urandom >> $urandom_range(31, 0);
          if (b == 32'd0) b = 32'd3;
          issue(a, b, 1'b1, model(a, b, 1'b1), 0);
        end
      endcase
      collect(got, lat, res);
      e = sb.pop_front();
      checks++;
      if (!got || lat != e.lat) begin
        errors++; $display("FAIL signed_latency[%0d]: got %0d (seen %0b) expected %0d", i, lat, got, e.lat);
      end
      checks++;
      if (res !== e.res) begin
        errors++; $display("FAIL signed_result[%0d]: a=%h b=%h got %h expected %h", i, a, b, res, e.res);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_divzero();
    bit got; int lat; logic [63:0] res; exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue((i == 0) ? 32'h1234 : 32'hFFFF_FFFB, 32'd0, i[0], 64'h0, 0);
      collect(got, lat, res);
      e = sb.pop_front();
      checks++;
      if (!got || lat != e.lat) begin
        errors++; $display("FAIL divzero_latency[%0d]: got %0d (seen %0b) expected %0d", i, lat, got, e.lat);
      end
      checks++;
      if (res !== e.res) begin
        errors++; $display("FAIL divzero_result[%0d]: got %h expected %h", i, res, e.res);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ready_o !== 1'b0) begin
        errors++; $display("FAIL divzero_pulse[%0d]: ready %0b expected 0", i, ready_o);
      end
    end
  endtask

  task automatic test_overflow();
    bit got; int lat; logic [63:0] res; exp_t e;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, 0);
    collect(got, lat, res);
    e = sb.pop_front();
    checks++;
    if (!got || res !== e.res) begin
      errors++; $display("FAIL overflow_signed: got %h (seen %0b) expected %h", res, got, e.res);
    end
    @(posedge clk);
    #1;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 64'h80000000_00000000, 0);
    collect(got, lat, res);
    e = sb.pop_front();
    checks++;
    if (!got || res !== e.res) begin
      errors++; $display("FAIL overflow_unsigned: got %h (seen %0b) expected %h", res, got, e.res);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_annul();
    int pulses;
    bit got; int lat; logic [63:0] res; exp_t e;
    // Annul mid-BUSY; result_o holds a non-zero value from the previous test
    opdata1 = 32'd1000; opdata2 = 32'd7; signed_div = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0; start_i = 1'b0;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL annul_clear: ready %0b result %h expected 0/0", ready_o, result_o);
    end
    count_ready(40, pulses);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL annul_no_ready: got %0d pulses expected 0", pulses);
    end
    // annul together with start in IDLE must not accept
    annul_i = 1'b1; start_i = 1'b1;
    @(posedge clk);
    #1 annul_i = 1'b0; start_i = 1'b0;
    count_ready(36, pulses);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL annul_start_idle: got %0d pulses expected 0", pulses);
    end
    issue(32'd1000, 32'd7, 1'b0, 64'h00000006_0000008E, 0);
    collect(got, lat, res);
    e = sb.pop_front();
    checks++;
    if (!got || lat != e.lat || res !== e.res) begin
      errors++; $display("FAIL annul_restart: lat %0d res %h expected %0d %h", lat, res, e.lat, e.res);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int pulses;
    bit got; int lat; logic [63:0] res; exp_t e;
    opdata1 = 32'd12345; opdata2 = 32'd10; signed_div = 1'b0; start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (ready_o !== 1'b0 || result_o !== 64'h0) begin
      errors++; $display("FAIL async_reset: ready %0b result %h expected 0/0", ready_o, result_o);
    end
    #1 rst = 1'b0;
    count_ready(40, pulses);
    checks++;
    if (pulses != 0) begin
      errors++; $display("FAIL reset_no_ready: got %0d pulses expected 0", pulses);
    end
    // Operand changes after accept must not matter
    issue(32'hFFFF_FF9C, 32'd7, 1'b1, model(32'hFFFF_FF9C, 32'd7, 1'b1), 0);
    opdata1 = 32'h5555_5555; opdata2 = 32'd0; signed_div = 1'b0;
    collect(got, lat, res);
    e = sb.pop_front();
    checks++;
    if (!got || lat != e.lat || res !== e.res) begin
      errors++; $display("FAIL operand_hold: lat %0d res %h expected %0d %h", lat, res, e.lat, e.res);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bit got; int lat; logic [63:0] res; exp_t e;
    issue(32'd77, 32'd5, 1'b0, model(32'd77, 32'd5, 1'b0), 0);
    for (int i = 0; i < 3; i++) begin
      collect(got, lat, res);
      e = sb.pop_front();
      checks++;
      if (!got || lat != e.lat || res !== e.res) begin
        errors++; $display("FAIL back_to_back[%0d]: lat %0d res %h expected %0d %h", i, lat, res, e.lat, e.res);
      end
      // start raised during DONE: ignored there, accepted on the following IDLE edge
      if (i < 2) issue(32'd900 + i, 32'd11 + i, 1'b0, model(32'd900 + i, 32'd11 + i, 1'b0), 1);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; signed_div = 1'b0; opdata1 = '0; opdata2 = '0;
    start_i = 1'b0; annul_i = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_overflow();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock, shared with pipeline registers.
REQ-003 rst  input  1  async active-high reset.
REQ-004 signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled only at accept.
REQ-005 opdata1  input  32  dividend; sampled only at accept.
REQ-006 opdata2  input  32  divisor; sampled only at accept.
REQ-007 start_i  input  1  divide request, driven by the hazard unit's div_start.
REQ-008 annul_i  input  1  cancel, driven by the EX flush; aborts any operation.
REQ-009 result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}; registered.
REQ-010 ready_o  output  1  result valid, one-cycle pulse; feeds the hazard unit's div_ready; registered.

Function
REQ-011 The block SHALL implement four states: IDLE, BUSY, DIVZERO and DONE.
REQ-012 In IDLE with start_i=1 and annul_i=0, the block SHALL latch the operands and signed_div at the clock edge (accept, cycle T).
REQ-013 At accept with opdata2=0, the block SHALL go to DIVZERO; otherwise it SHALL go to BUSY with the iteration counter at 0.
REQ-014 At accept, the block SHALL store the operand magnitudes: absolute value of each operand when signed, raw values when unsigned; magnitudes are 32-bit unsigned, so 0x80000000 maps to 0x80000000.
REQ-015 It SHALL record quotient sign = sign1 XOR sign2 and remainder sign = sign1; both are 0 when unsigned.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle, for exactly 32 cycles (T+1..T+32).
REQ-017 Each step SHALL use a 33-bit partial remainder: shift left, bring in the next dividend bit MSB-first, and trial-subtract the divisor.
REQ-018 If the trial difference is non-negative, the step SHALL keep the difference and shift 1 into the quotient; otherwise it SHALL keep the shifted value and shift 0 into the quotient.
REQ-019 When the counter reaches 32, the block SHALL go to DONE and load result_o with the sign-corrected values.
REQ-020 Sign correction SHALL negate (two's complement, modulo 2^32) the quotient when its sign is 1, and the remainder when its sign is 1.
REQ-021 DIVZERO SHALL last one cycle, then go to DONE with result_o = 64'h0.
REQ-022 DONE SHALL drive ready_o=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-023 ready_o SHALL be 0 in all states other than DONE.
REQ-024 Latency SHALL be: ready_o high at cycle T+33 for a non-zero divisor, and at T+2 for a zero divisor.
REQ-025 result_o SHALL hold its last value until the next DONE load, reset, or annul.
REQ-026 The block SHALL ignore changes to opdata1, opdata2 and signed_div after accept.
REQ-027 The block SHALL ignore start_i in BUSY, DIVZERO and DONE.
REQ-028 If start_i is high in the cycle after DONE, the block SHALL accept a new operation; preventing that restart is the upstream hazard unit's job.
REQ-029 annul_i=1 in any state SHALL force IDLE at the next edge, with ready_o=0, the counter cleared and result_o cleared to 0.
REQ-030 annul_i SHALL take priority over start_i and over the DONE transition.
REQ-031 When annul_i and start_i are high together in IDLE, the block SHALL NOT accept.
REQ-032 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0 (wrap), with no exception raised.

Reset
REQ-033 rst=1 SHALL, asynchronously: set the state to IDLE, set ready_o=0, set result_o=64'h0, clear the counter and clear all latched operands and signs.
REQ-034 rst asserted mid-operation SHALL abandon the operation, and the block SHALL NOT assert ready_o for it after rst is released.
REQ-035 After rst is released, the first accept SHALL occur on the first edge with start_i=1 and annul_i=0.

Verification
REQ-036 Unsigned: opdata1=7, opdata2=2, signed_div=0, start held -> ready_o pulse at T+33, result_o=64'h00000001_00000003.
REQ-037 Signed: -7 / 2 -> result_o=64'hFFFFFFFF_FFFFFFFD; 7 / -2 -> result_o=64'h00000001_FFFFFFFD.
REQ-038 Divide by zero: opdata1=0x1234, opdata2=0 -> ready_o at T+2, result_o=64'h0.
REQ-039 Overflow: 0x80000000 / 0xFFFFFFFF signed -> result_o=64'h00000000_80000000; the same operands unsigned -> result_o=64'h80000000_00000000.
REQ-040 Annul in BUSY at T+10 -> IDLE at T+11, no ready_o pulse, result_o=0; a new start at T+12 completes correctly at T+45.
REQ-041 Reset and hold: async rst pulse mid-BUSY -> immediate IDLE, ready_o stays 0; operand changes during BUSY do not affect result_o.
